// File: rtl/psum_acc_pkg.sv
// ---------------------------------------------------------------------------
// psum_acc_pkg
// Shared definitions for the partial-sum accumulator:
//   - state_e      : controller states (IDLE / ACCUM / DRAIN)
//   - PASS_W       : width of the pass counter / num_pass_m1 field
//   - SAT_MAX_BW   : widest lane the saturating helper supports
//   - sat_clip()   : clamps a sign-extended sum into a bw-bit signed range;
//                    only referenced when PSUM_ACC_SAT_EN is defined
// ---------------------------------------------------------------------------
package psum_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int PASS_W     = 8;
  localparam int SAT_MAX_BW = 32;

  // Clamp a (bw+1)-bit sum, sign-extended to SAT_MAX_BW+1 bits, into
  // [-2^(bw-1), 2^(bw-1)-1]. Callers truncate the result to bw bits.
  function automatic logic signed [SAT_MAX_BW:0] sat_clip(
    input logic signed [SAT_MAX_BW:0] sum,
    input int                         bw
  );
    logic signed [SAT_MAX_BW:0] hi;
    logic signed [SAT_MAX_BW:0] lo;
    logic signed [SAT_MAX_BW:0] res;
    hi = (33'sd1 <<< (bw - 1)) - 33'sd1;
    lo = -hi - 33'sd1;
    if (sum > hi) begin
      res = hi;
    end else if (sum < lo) begin
      res = lo;
    end else begin
      res = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// ---------------------------------------------------------------------------
// psum_accumulator_if
// Input and output valid/ready streams of the accumulator.
//   in_valid / in_ready / in_data    : psum vectors from the output FIFO drain
//   out_valid / out_ready / out_data : accumulated vectors to the SRAM path
// Modports: master = traffic source/sink around the block, slave = block.
// ---------------------------------------------------------------------------
interface psum_accumulator_if #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [COL*PSUM_BW-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [COL*PSUM_BW-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/psum_acc_lane.sv
// ---------------------------------------------------------------------------
// psum_acc_lane
// One lane of the accumulator datapath (purely combinational).
//   i_cur     : current buffer contents at the active position
//   i_data    : incoming lane value
//   i_first   : first pass -> overwrite instead of accumulate
//   o_wr      : value to write back into the buffer
//   i_relu_en : zero negative values on the read path
//   o_rd      : drained lane value
// Build option: PSUM_ACC_SAT_EN selects saturating addition; otherwise the
// sum wraps modulo 2^PSUM_BW.
// ---------------------------------------------------------------------------
module psum_acc_lane
  import psum_acc_pkg::*;
#(
  parameter int PSUM_BW = 16
) (
  input  logic [PSUM_BW-1:0] i_cur,
  input  logic [PSUM_BW-1:0] i_data,
  input  logic               i_first,
  input  logic               i_relu_en,
  output logic [PSUM_BW-1:0] o_wr,
  output logic [PSUM_BW-1:0] o_rd
);

  logic [PSUM_BW-1:0] w_add;

`ifdef PSUM_ACC_SAT_EN
  // One extra bit of headroom exposes overflow before clamping.
  logic signed [PSUM_BW:0]    w_sum_ext;
  logic signed [SAT_MAX_BW:0] w_sum_wide;

  assign w_sum_ext  = $signed({i_cur[PSUM_BW-1], i_cur}) +
                      $signed({i_data[PSUM_BW-1], i_data});
  assign w_sum_wide = {{(SAT_MAX_BW-PSUM_BW){w_sum_ext[PSUM_BW]}}, w_sum_ext};
  assign w_add      = PSUM_BW'(sat_clip(w_sum_wide, PSUM_BW));
`else
  // Two's-complement truncation: the carry out is simply dropped.
  assign w_add = i_cur + i_data;
`endif

  assign o_wr = i_first ? i_data : w_add;
  assign o_rd = (i_relu_en && i_cur[PSUM_BW-1]) ? {PSUM_BW{1'b0}} : i_cur;

endmodule

// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
// Multi-pass partial-sum accumulator. A tile of num_pix_m1+1 positions is
// accumulated over num_pass_m1+1 passes into an on-chip buffer, then drained
// in position order with optional ReLU.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_start         : one-cycle launch pulse, honoured only when idle
//   i_num_pix_m1    : positions per pass minus one (latched on start)
//   i_num_pass_m1   : passes minus one (latched on start)
//   i_relu_en       : ReLU on drain (latched on start)
//   bus             : input/output valid-ready streams (slave modport)
//   o_busy          : controller not idle
//   o_done          : one-cycle pulse after the final output handshake
// Build option: PSUM_ACC_SAT_EN (saturating lane addition).
// ---------------------------------------------------------------------------
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [$clog2(DEPTH)-1:0] i_num_pix_m1,
  input  logic [PASS_W-1:0]        i_num_pass_m1,
  input  logic                     i_relu_en,
  psum_accumulator_if.slave        bus,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int VW = COL * PSUM_BW;
  localparam logic [PW-1:0]     PIX_ONE  = PW'(1);
  localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

  state_e              r_state;
  logic [PW-1:0]       r_pix_ptr;
  logic [PASS_W-1:0]   r_pass_cnt;
  logic [PW-1:0]       r_num_pix_m1;
  logic [PASS_W-1:0]   r_num_pass_m1;
  logic                r_relu_en;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_done;
  logic [VW-1:0]       r_buf [DEPTH];

  logic                w_in_hs;
  logic                w_out_hs;
  logic                w_last_pix;
  logic                w_last_pass;
  logic                w_first_pass;
  logic [VW-1:0]       w_cur;
  logic [VW-1:0]       w_wr_data;
  logic [VW-1:0]       w_rd_data;

  assign w_in_hs      = bus.in_valid & r_in_ready;
  assign w_out_hs     = r_out_valid & bus.out_ready;
  assign w_last_pix   = (r_pix_ptr == r_num_pix_m1);
  assign w_last_pass  = (r_pass_cnt == r_num_pass_m1);
  assign w_first_pass = (r_pass_cnt == {PASS_W{1'b0}});
  // Accumulate and drain never overlap, so one buffer read port serves both.
  assign w_cur        = r_buf[r_pix_ptr];

  for (genvar g = 0; g < COL; g++) begin : g_lane
    psum_acc_lane #(
      .PSUM_BW (PSUM_BW)
    ) u_lane (
      .i_cur     (w_cur[g*PSUM_BW +: PSUM_BW]),
      .i_data    (bus.in_data[g*PSUM_BW +: PSUM_BW]),
      .i_first   (w_first_pass),
      .i_relu_en (r_relu_en),
      .o_wr      (w_wr_data[g*PSUM_BW +: PSUM_BW]),
      .o_rd      (w_rd_data[g*PSUM_BW +: PSUM_BW])
    );
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  // Gated so the port reads zero whenever nothing is being offered.
  assign bus.out_data  = r_out_valid ? w_rd_data : {VW{1'b0}};
  assign o_busy        = r_busy;
  assign o_done        = r_done;

  // Controller: state, counters, config latches and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pix_ptr     <= {PW{1'b0}};
      r_pass_cnt    <= {PASS_W{1'b0}};
      r_num_pix_m1  <= {PW{1'b0}};
      r_num_pass_m1 <= {PASS_W{1'b0}};
      r_relu_en     <= 1'b0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_num_pix_m1  <= i_num_pix_m1;
            r_num_pass_m1 <= i_num_pass_m1;
            r_relu_en     <= i_relu_en;
            r_pix_ptr     <= {PW{1'b0}};
            r_pass_cnt    <= {PASS_W{1'b0}};
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_in_hs) begin
            if (w_last_pix) begin
              r_pix_ptr <= {PW{1'b0}};
              if (w_last_pass) begin
                r_pass_cnt  <= {PASS_W{1'b0}};
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
                r_state     <= ST_DRAIN;
              end else begin
                r_pass_cnt <= r_pass_cnt + PASS_ONE;
              end
            end else begin
              r_pix_ptr <= r_pix_ptr + PIX_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (w_out_hs) begin
            if (w_last_pix) begin
              r_pix_ptr   <= {PW{1'b0}};
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_pix_ptr <= r_pix_ptr + PIX_ONE;
            end
          end
        end
        default: begin
          r_pix_ptr   <= {PW{1'b0}};
          r_pass_cnt  <= {PASS_W{1'b0}};
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Buffer: written only on an accepted input vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= {VW{1'b0}};
      end
    end else if (w_in_hs) begin
      r_buf[r_pix_ptr] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_psum_accumulator
// Randomised and directed tiles against an arithmetic reference model.
// Expected drain vectors are queued when a tile is launched; a monitor pops
// and compares them on every output handshake, checks output stability under
// backpressure and counts done pulses.
// ---------------------------------------------------------------------------
module tb_psum_accumulator;
  import psum_acc_pkg::*;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int VW    = COL * BW;
  localparam int MAXP  = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [3:0]        num_pix_m1;
  logic [PASS_W-1:0] num_pass_m1;
  logic              relu_en;
  logic              busy;
  logic              done;

  psum_accumulator_if #(.COL(COL), .PSUM_BW(BW)) bus ();

  psum_accumulator #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_num_pix_m1  (num_pix_m1),
    .i_num_pass_m1 (num_pass_m1),
    .i_relu_en     (relu_en),
    .bus           (bus.slave),
    .o_busy        (busy),
    .o_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic [VW-1:0] exp_q [$];
  int vin [MAXP][DEPTH][COL];

  task automatic chk(input bit ok, input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int to16(input int s);
    int r;
    r = s & 32'h0000FFFF;
    if (r >= 32768) r = r - 65536;
    return r;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic logic [VW-1:0] pack_in(input int p, input int x);
    logic [VW-1:0] v;
    for (int l = 0; l < COL; l++) v[l*BW +: BW] = 16'(vin[p][x][l]);
    return v;
  endfunction

  // Reference: sum each position over all passes with plain integer maths.
  task automatic push_expected(input int npix_m1, input int npass_m1, input bit relu);
    int acc [DEPTH][COL];
    int s;
    logic [VW-1:0] v;
    for (int p = 0; p <= npass_m1; p++)
      for (int x = 0; x <= npix_m1; x++)
        for (int l = 0; l < COL; l++) begin
          if (p == 0) acc[x][l] = vin[p][x][l];
          else begin
            s = acc[x][l] + vin[p][x][l];
`ifdef PSUM_ACC_SAT_EN
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`else
            s = to16(s);
`endif
            acc[x][l] = s;
          end
        end
    for (int x = 0; x <= npix_m1; x++) begin
      for (int l = 0; l < COL; l++)
        v[l*BW +: BW] = 16'((relu && acc[x][l] < 0) ? 0 : acc[x][l]);
      exp_q.push_back(v);
    end
  endtask

  task automatic fill_rand(input int npix_m1, input int npass_m1);
    for (int p = 0; p <= npass_m1; p++)
      for (int x = 0; x <= npix_m1; x++)
        for (int l = 0; l < COL; l++) vin[p][x][l] = rnd16();
  endtask

  // Monitor: data compare on handshake, stall stability, done counting.
  logic          hold_pend = 1'b0;
  logic [VW-1:0] held;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend)
        chk(bus.out_valid && (bus.out_data == held), "hold", bus.out_data, held);
      hold_pend = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        hold_pend = 1'b1;
        held = bus.out_data;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_out", bus.out_data, '0);
        else begin
          logic [VW-1:0] e;
          e = exp_q.pop_front();
          chk(bus.out_data == e, "drain_data", bus.out_data, e);
        end
      end
      if (done) done_cnt++;
    end
  end

  // ready_mode: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  task automatic run_tile(input int npix_m1, input int npass_m1, input bit relu,
                          input int ready_mode, input bit inject);
    int guard;
    int k;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    push_expected(npix_m1, npass_m1, relu);
    done_cnt = 0;
    start = 1'b1; num_pix_m1 = 4'(npix_m1); num_pass_m1 = 8'(npass_m1); relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0;
    chk(bus.in_ready && busy, "start_latency", {126'd0, bus.in_ready, busy}, 128'd3);
    for (int p = 0; p <= npass_m1; p++)
      for (int x = 0; x <= npix_m1; x++) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0; @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = pack_in(p, x);
        if (inject && p == 0 && x == 0) begin
          start = 1'b1; num_pix_m1 = ~4'(npix_m1); num_pass_m1 = 8'(npass_m1 + 3); relu_en = ~relu;
        end
        chk(bus.in_ready, "in_ready_accum", {127'd0, bus.in_ready}, 128'd1);
        @(posedge clk); #1;
        start = 1'b0;
      end
    bus.in_valid = 1'b0;
    chk(bus.out_valid && busy, "drain_entry", {127'd0, bus.out_valid}, 128'd1);
    guard = 0; k = 0;
    while (busy && guard < 400) begin
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = pat[k % 4];
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (inject && guard == 0) begin
        start = 1'b1; num_pix_m1 = 4'd0; num_pass_m1 = 8'd0; relu_en = ~relu;
      end
      k++;
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
    end
    bus.out_ready = 1'b0;
    chk(guard < 400, "drain_timeout", 128'(guard), 128'd400);
    chk(done && !busy, "done_pulse", {126'd0, done, busy}, 128'd2);
    @(posedge clk); #1;
    chk(!done && !busy, "done_once_idle", {126'd0, done, busy}, 128'd0);
    chk(done_cnt == 1, "done_count", 128'(done_cnt), 128'd1);
    chk(exp_q.size() == 0, "all_drained", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; num_pix_m1 = 4'd0; num_pass_m1 = 8'd0; relu_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #23;
    chk({bus.in_ready, bus.out_valid, busy, done} == 4'd0 && bus.out_data == '0,
        "reset_outputs", {124'd0, bus.in_ready, bus.out_valid, busy, done}, 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // in_valid while idle must not be accepted
    bus.in_valid = 1'b1; bus.in_data = {VW{1'b1}};
    repeat (3) begin
      @(posedge clk); #1;
      chk(!bus.in_ready && !busy, "idle_no_accept", {127'd0, bus.in_ready}, 128'd0);
    end
    bus.in_valid = 1'b0;

    // single pass: values 1..4 in every lane
    for (int x = 0; x < 4; x++) for (int l = 0; l < COL; l++) vin[0][x][l] = x + 1;
    run_tile(3, 0, 1'b0, 0, 1'b0);

    // three passes, lane 0 directed, without and with ReLU
    for (int r = 0; r < 2; r++) begin
      fill_rand(1, 2);
      vin[0][0][0] = 10; vin[0][1][0] = 20;
      vin[1][0][0] = -3; vin[1][1][0] = 5;
      vin[2][0][0] = 4;  vin[2][1][0] = -30;
      run_tile(1, 2, r[0], 0, 1'b0);
    end

    // overflow: two passes of 0x7000 (and of -0x7000 on odd lanes)
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < COL; l++) vin[p][0][l] = l[0] ? -28672 : 28672;
    run_tile(0, 1, 1'b0, 0, 1'b0);

    // backpressure with 1,0,0,1 ready pattern and ignored starts
    fill_rand(5, 1);
    run_tile(5, 1, 1'b0, 1, 1'b1);

    // reset in the middle of accumulation after 5 inputs
    fill_rand(7, 1);
    start = 1'b1; num_pix_m1 = 4'd7; num_pass_m1 = 8'd1; relu_en = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int x = 0; x < 5; x++) begin
      bus.in_valid = 1'b1; bus.in_data = pack_in(0, x);
      @(posedge clk); #1;
    end
    rst_n = 1'b0; bus.in_valid = 1'b0;
    #2;
    chk({bus.in_ready, bus.out_valid, busy, done} == 4'd0 && bus.out_data == '0,
        "midtile_reset", {124'd0, bus.in_ready, bus.out_valid, busy, done}, 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk(!busy && !bus.in_ready, "post_reset_idle", {126'd0, busy, bus.in_ready}, 128'd0);
    fill_rand(7, 0);
    run_tile(7, 0, 1'b0, 0, 1'b0);

    // randomised tiles
    for (int t = 0; t < 8; t++) begin
      int np, nq;
      np = $urandom_range(0, DEPTH - 1);
      nq = $urandom_range(0, 3);
      fill_rand(np, nq);
      run_tile(np, nq, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
    end

    // full depth, max random passes in table
    fill_rand(DEPTH - 1, MAXP - 1);
    run_tile(DEPTH - 1, MAXP - 1, 1'b1, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
